// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: access-width codes, FSM encoding,
// bus timeout default and the access legality check.
package mem_pkg;

  localparam int TIMEOUT_DEF = 16;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  // Legal width code for the access kind and naturally aligned address.
  function automatic logic access_ok(input logic is_store, input logic [2:0] funct3,
                                     input logic [1:0] offset);
    logic legal_s;
    logic aligned_s;
    legal_s   = 1'b0;
    aligned_s = 1'b0;
    case (funct3)
      LB:      begin legal_s = 1'b1;      aligned_s = 1'b1;               end
      LH:      begin legal_s = 1'b1;      aligned_s = ~offset[0];         end
      LW:      begin legal_s = 1'b1;      aligned_s = (offset == 2'b00);  end
      LBU:     begin legal_s = ~is_store; aligned_s = 1'b1;               end
      LHU:     begin legal_s = ~is_store; aligned_s = ~offset[0];         end
      default: begin legal_s = 1'b0;      aligned_s = 1'b0;               end
    endcase
    return legal_s & aligned_s;
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane formatting: store replication/strobes and
// load extract/extend.
module load_store_align
  import mem_pkg::*;
(
  input  logic        st_en,
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_offset,
  input  logic [31:0] st_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wstrb,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [3:0]  strb_s;
  logic [31:0] ld_raw_s;

  assign st_wstrb = st_en ? strb_s : 4'b0000;
  assign ld_raw_s = ld_rdata >> {ld_offset, 3'b000};

  // Store data replicated across every lane; strobes pick the addressed bytes.
  always_comb begin
    st_wdata = st_data;
    strb_s   = 4'b0000;
    case (st_funct3)
      SB:      begin st_wdata = {4{st_data[7:0]}};  strb_s = 4'b0001 << st_offset; end
      SH:      begin st_wdata = {2{st_data[15:0]}}; strb_s = 4'b0011 << st_offset; end
      SW:      begin st_wdata = st_data;            strb_s = 4'b1111;              end
      default: begin st_wdata = st_data;            strb_s = 4'b0000;              end
    endcase
  end

  // Load extract from the shifted word, then sign or zero extension.
  always_comb begin
    ld_data = ld_raw_s;
    case (ld_funct3)
      LB:      ld_data = {{24{ld_raw_s[7]}}, ld_raw_s[7:0]};
      LBU:     ld_data = {24'd0, ld_raw_s[7:0]};
      LH:      ld_data = {{16{ld_raw_s[15]}}, ld_raw_s[15:0]};
      LHU:     ld_data = {16'd0, ld_raw_s[15:0]};
      LW:      ld_data = ld_raw_s;
      default: ld_data = ld_raw_s;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the RV32I pipeline: req/ack data-memory transaction with
// timeout, load/store lane alignment, and the MEM/WB pipeline register.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MEM_valid,
  input  logic [XLEN-1:0] MEM_ALU_out,
  input  logic [XLEN-1:0] MEM_Data_out,
  input  logic [4:0]      MEM_Rd_addr,
  input  logic            MEM_RegWrite,
  input  logic            MEM_MemRead,
  input  logic            MEM_MemWrite,
  input  logic [2:0]      MEM_funct3,
  output logic [XLEN-1:0] MEM_Rd_data,
  output logic            mem_stall,
  output logic            mem_fault,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wstrb,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic [4:0]      WB_Rd_addr,
  output logic            WB_RegWrite,
  output logic [XLEN-1:0] WB_Rd_data
);

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_e       state_r, state_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic             memop_s, ok_s, timeout_s;
  logic             stall_s, fault_s, latch_req_s, wb_load_s, wb_we_s;
  logic [XLEN-1:0]  wb_data_s, st_wdata_s, ld_data_s, rdata_r;
  logic [3:0]       st_wstrb_s;
  logic [2:0]       funct3_r;
  logic [1:0]       offset_r;
  logic             load_r, err_r;
  logic             dmem_req_r, dmem_we_r;
  logic [XLEN-1:0]  dmem_addr_r, dmem_wdata_r;
  logic [3:0]       dmem_wstrb_r;
  logic [4:0]       wb_rd_addr_r;
  logic             wb_regwrite_r;
  logic [XLEN-1:0]  wb_rd_data_r;

  assign memop_s     = MEM_valid & (MEM_MemRead | MEM_MemWrite);
  assign ok_s        = access_ok(MEM_MemWrite, MEM_funct3, MEM_ALU_out[1:0]);
  assign timeout_s   = (cnt_r == CNT_LAST);
  assign MEM_Rd_data = MEM_ALU_out;
  assign mem_stall   = stall_s & ~rst;
  assign mem_fault   = fault_s & ~rst;
  assign dmem_req    = dmem_req_r;
  assign dmem_we     = dmem_we_r;
  assign dmem_addr   = dmem_addr_r;
  assign dmem_wdata  = dmem_wdata_r;
  assign dmem_wstrb  = dmem_wstrb_r;
  assign WB_Rd_addr  = wb_rd_addr_r;
  assign WB_RegWrite = wb_regwrite_r;
  assign WB_Rd_data  = wb_rd_data_r;

  load_store_align u_align (
    .st_en     (MEM_MemWrite),
    .st_funct3 (MEM_funct3),
    .st_offset (MEM_ALU_out[1:0]),
    .st_data   (MEM_Data_out),
    .st_wdata  (st_wdata_s),
    .st_wstrb  (st_wstrb_s),
    .ld_funct3 (funct3_r),
    .ld_offset (offset_r),
    .ld_rdata  (rdata_r),
    .ld_data   (ld_data_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nx_s;
  end

  // Next state, stall/fault and MEM/WB load control.
  always_comb begin
    state_nx_s  = state_r;
    stall_s     = 1'b0;
    fault_s     = 1'b0;
    latch_req_s = 1'b0;
    wb_load_s   = 1'b0;
    wb_we_s     = 1'b0;
    wb_data_s   = MEM_ALU_out;
    case (state_r)
      IDLE: begin
        if (memop_s && ok_s) begin
          stall_s     = 1'b1;
          latch_req_s = 1'b1;
          state_nx_s  = REQ;
        end else if (memop_s) begin
          fault_s   = 1'b1;
          wb_load_s = 1'b1;
        end else begin
          wb_load_s = 1'b1;
          wb_we_s   = MEM_valid & MEM_RegWrite;
        end
      end
      REQ: begin
        stall_s = 1'b1;
        if (dmem_ack)       state_nx_s = DONE;
        else if (timeout_s) state_nx_s = DONE;
        else                state_nx_s = REQ;
      end
      DONE: begin
        state_nx_s = IDLE;
        wb_load_s  = 1'b1;
        fault_s    = err_r;
        if (load_r && !err_r) begin
          wb_we_s   = MEM_valid & MEM_RegWrite;
          wb_data_s = ld_data_s;
        end else begin
          wb_we_s   = 1'b0;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Request registers, timeout counter and load-data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req_r   <= 1'b0;
      dmem_we_r    <= 1'b0;
      dmem_addr_r  <= {XLEN{1'b0}};
      dmem_wdata_r <= {XLEN{1'b0}};
      dmem_wstrb_r <= 4'b0000;
      funct3_r     <= 3'b000;
      offset_r     <= 2'b00;
      load_r       <= 1'b0;
      err_r        <= 1'b0;
      rdata_r      <= {XLEN{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
    end else begin
      dmem_req_r <= (state_nx_s == REQ);
      if (latch_req_s) begin
        dmem_addr_r  <= {MEM_ALU_out[XLEN-1:2], 2'b00};
        dmem_we_r    <= MEM_MemWrite;
        dmem_wdata_r <= st_wdata_s;
        dmem_wstrb_r <= st_wstrb_s;
        funct3_r     <= MEM_funct3;
        offset_r     <= MEM_ALU_out[1:0];
        load_r       <= MEM_MemRead;
        err_r        <= 1'b0;
      end
      if (state_r == REQ) begin
        cnt_r <= cnt_r + CNT_W'(1);
        if (dmem_ack)       rdata_r <= dmem_rdata;
        else if (timeout_s) err_r   <= 1'b1;
      end else begin
        cnt_r <= {CNT_W{1'b0}};
      end
    end
  end

  // MEM/WB pipeline register; a write to x0 is never reported.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_rd_addr_r  <= 5'd0;
      wb_regwrite_r <= 1'b0;
      wb_rd_data_r  <= {XLEN{1'b0}};
    end else if (wb_load_s) begin
      wb_rd_addr_r  <= MEM_Rd_addr;
      wb_regwrite_r <= wb_we_s & (MEM_Rd_addr != 5'd0);
      wb_rd_data_r  <= wb_data_s;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: transaction-level model drives
// per-cycle expectations that a negedge compare process checks.
module tb_mem_access_stage;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_valid, MEM_RegWrite, MEM_MemRead, MEM_MemWrite;
  logic [31:0] MEM_ALU_out, MEM_Data_out, MEM_Rd_data;
  logic [4:0]  MEM_Rd_addr;
  logic [2:0]  MEM_funct3;
  logic        mem_stall, mem_fault, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic [4:0]  WB_Rd_addr;
  logic        WB_RegWrite;
  logic [31:0] WB_Rd_data;

  mem_access_stage #(.TIMEOUT(TMO), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .MEM_valid(MEM_valid), .MEM_ALU_out(MEM_ALU_out), .MEM_Data_out(MEM_Data_out),
    .MEM_Rd_addr(MEM_Rd_addr), .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead),
    .MEM_MemWrite(MEM_MemWrite), .MEM_funct3(MEM_funct3), .MEM_Rd_data(MEM_Rd_data),
    .mem_stall(mem_stall), .mem_fault(mem_fault), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .WB_Rd_addr(WB_Rd_addr),
    .WB_RegWrite(WB_RegWrite), .WB_Rd_data(WB_Rd_data)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        chk_en   = 1'b0;
  logic        exp_stall, exp_fault, exp_req, exp_we;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_wstrb;
  logic [4:0]  exp_wb_addr;
  logic        exp_wb_rw;
  logic [31:0] exp_wb_data;
  int          obs_stall, obs_fault, obs_req;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_wstrb;

  logic [2:0]  ld_f3s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  int          kind, r_ack;
  logic        r_v, r_rd, r_wr, r_rw;
  logic [2:0]  r_f3;
  logic [4:0]  r_rdaddr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of DUT outputs against the model's expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_stall", 32'(mem_stall), 32'(exp_stall));
      check("mem_fault", 32'(mem_fault), 32'(exp_fault));
      check("dmem_req", 32'(dmem_req), 32'(exp_req));
      if (exp_req) begin
        check("dmem_addr", dmem_addr, exp_addr);
        check("dmem_we", 32'(dmem_we), 32'(exp_we));
        check("dmem_wstrb", 32'(dmem_wstrb), 32'(exp_wstrb));
        if (exp_we) check("dmem_wdata", dmem_wdata, exp_wdata);
      end
      check("WB_Rd_addr", 32'(WB_Rd_addr), 32'(exp_wb_addr));
      check("WB_RegWrite", 32'(WB_RegWrite), 32'(exp_wb_rw));
      check("WB_Rd_data", WB_Rd_data, exp_wb_data);
      check("MEM_Rd_data", MEM_Rd_data, MEM_ALU_out);
      obs_stall += int'(mem_stall);
      obs_fault += int'(mem_fault);
      if (dmem_req) begin
        obs_req++;
        obs_addr  = dmem_addr;
        obs_wdata = dmem_wdata;
        obs_wstrb = dmem_wstrb;
      end
    end
  end

  // One instruction through MEM: ack_dly = REQ cycle of ack (1-based), 0 = never.
  task automatic run_instr(input logic v, input logic rd_en, input logic wr_en,
                           input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] sd,
                           input logic [4:0] rd, input logic rw, input int ack_dly,
                           input logic [31:0] rdat);
    int nbytes, off, n_req;
    logic memop, legal, ok, tmo;
    logic [31:0] raw, mask, ldv;
    memop  = v && (rd_en || wr_en);
    nbytes = 1 << int'(f3[1:0]);
    off    = int'(alu[1:0]);
    legal  = (!rd_en || (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) &&
             (!wr_en || (f3 inside {3'd0, 3'd1, 3'd2}));
    ok     = legal && ((off % nbytes) == 0);
    MEM_valid = v; MEM_MemRead = rd_en; MEM_MemWrite = wr_en; MEM_funct3 = f3;
    MEM_ALU_out = alu; MEM_Data_out = sd; MEM_Rd_addr = rd; MEM_RegWrite = rw;
    dmem_ack = 1'b0; dmem_rdata = $urandom;
    obs_stall = 0; obs_fault = 0; obs_req = 0;
    obs_addr = 32'd0; obs_wdata = 32'd0; obs_wstrb = 4'd0;
    exp_addr  = alu & 32'hFFFF_FFFC;
    exp_we    = wr_en;
    exp_wdata = (nbytes == 1) ? 32'(sd[7:0]) * 32'h0101_0101 :
                (nbytes == 2) ? 32'(sd[15:0]) * 32'h0001_0001 : sd;
    exp_wstrb = wr_en ? 4'(((1 << nbytes) - 1) << off) : 4'd0;
    if (memop && ok) begin
      tmo   = (ack_dly == 0);
      n_req = tmo ? TMO : ack_dly;
      exp_stall = 1'b1; exp_req = 1'b0; exp_fault = 1'b0;
      @(posedge clk); #1;
      for (int j = 1; j <= n_req; j++) begin
        exp_req    = 1'b1;
        dmem_ack   = (j == ack_dly);
        dmem_rdata = (j == ack_dly) ? rdat : $urandom;
        @(posedge clk); #1;
      end
      exp_stall = 1'b0; exp_req = 1'b0; exp_fault = tmo;
      dmem_ack = 1'b0; dmem_rdata = $urandom;
      @(posedge clk); #1;
      exp_fault = 1'b0;
      if (rd_en && !tmo) begin
        raw  = rdat >> (8 * off);
        mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        ldv  = raw & mask;
        if (!f3[2] && nbytes < 4 && ldv[8 * nbytes - 1]) ldv = ldv | ~mask;
        exp_wb_data = ldv;
        exp_wb_rw   = rw && (rd != 5'd0);
      end else begin
        exp_wb_data = alu;
        exp_wb_rw   = 1'b0;
      end
    end else begin
      exp_stall = 1'b0; exp_req = 1'b0; exp_fault = memop;
      @(posedge clk); #1;
      exp_fault   = 1'b0;
      exp_wb_data = alu;
      exp_wb_rw   = !memop && v && rw && (rd != 5'd0);
    end
    exp_wb_addr = rd;
  endtask

  initial begin
    rst = 1'b1;
    MEM_valid = 1'b0; MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; MEM_RegWrite = 1'b0;
    MEM_funct3 = 3'd0; MEM_ALU_out = 32'd0; MEM_Data_out = 32'd0; MEM_Rd_addr = 5'd0;
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
    exp_stall = 1'b0; exp_fault = 1'b0; exp_req = 1'b0; exp_we = 1'b0;
    exp_addr = 32'd0; exp_wdata = 32'd0; exp_wstrb = 4'd0;
    exp_wb_addr = 5'd0; exp_wb_rw = 1'b0; exp_wb_data = 32'd0;
    #7;
    check("reset dmem_req", 32'(dmem_req), 32'd0);
    check("reset mem_stall", 32'(mem_stall), 32'd0);
    check("reset WB_RegWrite", 32'(WB_RegWrite), 32'd0);
    check("reset WB_Rd_data", WB_Rd_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // ALU pass-through
    run_instr(1'b1, 1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'd0, 5'd5, 1'b1, 0, 32'd0);
    check("alu WB_Rd_addr", 32'(WB_Rd_addr), 32'd5);
    check("alu WB_RegWrite", 32'(WB_RegWrite), 32'd1);
    check("alu WB_Rd_data", WB_Rd_data, 32'h0000_1234);
    check("alu stalls", 32'(obs_stall), 32'd0);

    // lb with ack in first REQ cycle
    run_instr(1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'd0, 5'd7, 1'b1, 1, 32'h80FF_0000);
    check("lb stalls", 32'(obs_stall), 32'd2);
    check("lb dmem_addr", obs_addr, 32'h0000_0100);
    check("lb WB_Rd_data", WB_Rd_data, 32'hFFFF_FF80);

    // sh with ack on the third REQ cycle
    run_instr(1'b1, 1'b0, 1'b1, 3'd1, 32'h0000_0202, 32'hAAAA_BEEF, 5'd3, 1'b0, 3, 32'd0);
    check("sh stalls", 32'(obs_stall), 32'd4);
    check("sh wdata", obs_wdata, 32'hBEEF_BEEF);
    check("sh wstrb", 32'(obs_wstrb), 32'h0000_000C);
    check("sh WB_RegWrite", 32'(WB_RegWrite), 32'd0);

    // misaligned lw
    run_instr(1'b1, 1'b1, 1'b0, 3'd2, 32'h0000_0101, 32'd0, 5'd9, 1'b1, 1, 32'd0);
    check("mis req cycles", 32'(obs_req), 32'd0);
    check("mis fault cycles", 32'(obs_fault), 32'd1);
    check("mis stalls", 32'(obs_stall), 32'd0);
    check("mis WB_RegWrite", 32'(WB_RegWrite), 32'd0);

    // lw that never gets an ack
    run_instr(1'b1, 1'b1, 1'b0, 3'd2, 32'h0000_0400, 32'd0, 5'd10, 1'b1, 0, 32'd0);
    check("tmo req cycles", 32'(obs_req), 32'd16);
    check("tmo fault cycles", 32'(obs_fault), 32'd1);
    check("tmo stalls", 32'(obs_stall), 32'd17);
    check("tmo WB_RegWrite", 32'(WB_RegWrite), 32'd0);

    // pipeline resumes; write to x0 suppressed
    run_instr(1'b1, 1'b0, 1'b0, 3'd0, 32'hCAFE_0001, 32'd0, 5'd0, 1'b1, 0, 32'd0);
    check("x0 WB_RegWrite", 32'(WB_RegWrite), 32'd0);
    check("x0 WB_Rd_data", WB_Rd_data, 32'hCAFE_0001);

    // reset in the middle of a REQ phase
    MEM_valid = 1'b1; MEM_MemRead = 1'b1; MEM_MemWrite = 1'b0; MEM_funct3 = 3'd2;
    MEM_ALU_out = 32'h0000_0300; MEM_Rd_addr = 5'd4; MEM_RegWrite = 1'b1;
    exp_stall = 1'b1; exp_req = 1'b0; exp_fault = 1'b0;
    @(posedge clk); #1;
    check("pre-rst dmem_req", 32'(dmem_req), 32'd1);
    #1;
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    check("rst dmem_req", 32'(dmem_req), 32'd0);
    check("rst mem_stall", 32'(mem_stall), 32'd0);
    check("rst WB_Rd_addr", 32'(WB_Rd_addr), 32'd0);
    check("rst WB_RegWrite", 32'(WB_RegWrite), 32'd0);
    check("rst WB_Rd_data", WB_Rd_data, 32'd0);
    @(posedge clk); #1;
    MEM_valid = 1'b0; MEM_MemRead = 1'b0;
    rst = 1'b0;
    exp_stall = 1'b0; exp_req = 1'b0; exp_fault = 1'b0;
    exp_wb_addr = 5'd0; exp_wb_rw = 1'b0; exp_wb_data = 32'd0;
    chk_en = 1'b1;
    run_instr(1'b1, 1'b0, 1'b0, 3'd0, 32'h0000_5555, 32'd0, 5'd6, 1'b1, 0, 32'd0);
    check("post-rst WB_Rd_data", WB_Rd_data, 32'h0000_5555);
    run_instr(1'b1, 1'b1, 1'b0, 3'd5, 32'h0000_0012, 32'd0, 5'd8, 1'b1, 2, 32'h9876_0000);
    check("post-rst lhu", WB_Rd_data, 32'h0000_9876);

    // randomized mix
    for (int i = 0; i < 250; i++) begin
      kind = $urandom_range(0, 9);
      r_v  = ($urandom_range(0, 7) != 0);
      r_rd = (kind >= 4) && (kind < 7);
      r_wr = (kind >= 7);
      if ($urandom_range(0, 3) == 0) r_f3 = 3'($urandom_range(0, 7));
      else if (r_wr)                 r_f3 = 3'($urandom_range(0, 2));
      else                           r_f3 = ld_f3s[$urandom_range(0, 4)];
      r_ack    = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 4);
      r_rdaddr = 5'($urandom);
      r_rw     = 1'($urandom);
      run_instr(r_v, r_rd, r_wr, r_f3, $urandom, $urandom, r_rdaddr, r_rw, r_ack, $urandom);
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
